// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial BCD adder, one digit per cycle (optional BCD_SUB_EN adds sub port)
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   a,
    input  logic [4*NDIG-1:0]   b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic [4*NDIG-1:0]   sum,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] LAST_DIG = 3'(NDIG - 1);

    logic [1:0]          state;
    logic [2:0]          dig_cnt;
    logic                carry;
    logic [4*NDIG-1:0]   a_q;
    logic [4*NDIG-1:0]   b_q;

    logic [4*NDIG-1:0]   b_load;
    logic                carry_load;
    logic                bad_digit;
    logic [3:0]          a_dig;
    logic [3:0]          b_dig;
    logic [4:0]          dig_sum;
    logic [3:0]          dig_res;
    logic                carry_next;

    // Subtraction folds into the adder as nine's complement of B plus a forced carry-in.
    always_comb begin
        b_load     = b;
        carry_load = cin;
        bad_digit  = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
`ifdef BCD_SUB_EN
            if (sub) begin
                b_load[4*k +: 4] = 4'd9 - b[4*k +: 4];
            end
`endif
        end
`ifdef BCD_SUB_EN
        if (sub) begin
            carry_load = 1'b1;
        end
`endif
    end

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_cnt == 3'(k)) begin
                a_dig = a_q[4*k +: 4];
                b_dig = b_q[4*k +: 4];
            end
        end
        dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry};
        // Adding 6 modulo 16 skips the six unused codes; bit 4 of s is discarded on purpose.
        if (dig_sum > 5'd9) begin
            dig_res    = dig_sum[3:0] + 4'd6;
            carry_next = 1'b1;
        end else begin
            dig_res    = dig_sum[3:0];
            carry_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dig_cnt <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ADD;
                        a_q     <= a;
                        b_q     <= b_load;
                        carry   <= carry_load;
                        sum     <= '0;
                        cout    <= 1'b0;
                        dig_cnt <= '0;
                        err     <= bad_digit;
                    end
                end
                S_ADD: begin
                    for (int k = 0; k < NDIG; k++) begin
                        if (dig_cnt == 3'(k)) begin
                            sum[4*k +: 4] <= dig_res;
                        end
                    end
                    carry <= carry_next;
                    if (dig_cnt == LAST_DIG) begin
                        cout  <= carry_next;
                        state <= S_DONE;
                    end else begin
                        dig_cnt <= dig_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_ADD) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - directed self-checking bench for bcd_serial_add_ctrl (NDIG=4)
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int BUDGET = 50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] a;
    logic [4*NDIG-1:0] b;
    logic              cin;
`ifdef BCD_SUB_EN
    logic              sub;
`endif
    logic [4*NDIG-1:0] sum;
    logic              cout;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives operands and start, then returns 1 time unit after the start edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic c);
        a     = av;
        b     = bv;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < BUDGET) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        checks++;
        if ({sum, cout, busy, done, err} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b err=%b, want all 0",
                     sum, cout, busy, done, err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_add_basic();
        int cyc;
        launch(16'h1234, 16'h5678, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after_start: busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles want %0d", cyc, NDIG);
        end
        checks++;
        if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_result: sum=%h cout=%b err=%b busy=%b want 6912/0/0/1",
                     sum, cout, err, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h6912) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b sum=%h want 0/0/6912", done, busy, sum);
        end
    endtask

    task automatic test_carry();
        int cyc;
        launch(16'h9999, 16'h0001, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG || sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_cin0: cyc=%0d sum=%h cout=%b want %0d/0000/1", cyc, sum, cout, NDIG);
        end
        tick();
        launch(16'h9999, 16'h0001, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG || sum !== 16'h0001 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_cin1: cyc=%0d sum=%h cout=%b want %0d/0001/1", cyc, sum, cout, NDIG);
        end
        tick();
    endtask

    task automatic test_err();
        int cyc;
        // Digit 1 is 0xA: 10 > 9 gives (10+6) mod 16 = 0 with carry into digit 2.
        launch(16'h00A0, 16'h0000, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_at_start: got %b want 1", err);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG || sum !== 16'h0100 || cout !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_result: cyc=%0d sum=%h cout=%b err=%b want %0d/0100/0/1",
                     cyc, sum, cout, err, NDIG);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || sum !== 16'h0100) begin
            errors++;
            $display("FAIL err_hold_idle: err=%b sum=%h want 1/0100", err, sum);
        end
        launch(16'h0001, 16'h0001, 1'b0);
        wait_done(cyc);
        checks++;
        if (err !== 1'b0 || sum !== 16'h0002) begin
            errors++;
            $display("FAIL err_cleared: err=%b sum=%h want 0/0002", err, sum);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int ndone;
        launch(16'h1234, 16'h5678, 1'b0);
        a = 16'h1111;
        b = 16'h1111;
        start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= NDIG; i++) begin
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_start_done_count: got %0d want 1", ndone);
        end
        checks++;
        if (sum !== 16'h6912 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: sum=%h busy=%b want 6912/0", sum, busy);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int ndone;
        launch(16'h1234, 16'h5678, 1'b0);
        tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum, cout, busy, done, err} !== 20'h0) begin
            errors++;
            $display("FAIL abort_outputs: sum=%h cout=%b busy=%b done=%b err=%b want all 0",
                     sum, cout, busy, done, err);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d busy=%b want 0/0", ndone, busy);
        end
        launch(16'h4321, 16'h0879, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG || sum !== 16'h5201 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: cyc=%0d sum=%h cout=%b want %0d/5201/0", cyc, sum, cout, NDIG);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 16'h0005;
        b = 16'h0005;
        cin = 1'b0;
        start = 1'b1;
        tick();
        wait_done(cyc);
        checks++;
        if (cyc !== NDIG || sum !== 16'h0010) begin
            errors++;
            $display("FAIL b2b_first: cyc=%0d sum=%h want %0d/0010", cyc, sum, NDIG);
        end
        tick();
        wait_done(cyc);
        checks++;
        if (cyc + 1 !== NDIG + 2) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles want %0d", cyc + 1, NDIG + 2);
        end
        start = 1'b0;
        tick();
        tick();
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        int cyc;
        sub = 1'b1;
        launch(16'h0500, 16'h0123, 1'b0);
        wait_done(cyc);
        checks++;
        if (sum !== 16'h0377 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_no_borrow: sum=%h cout=%b want 0377/1", sum, cout);
        end
        tick();
        launch(16'h0123, 16'h0500, 1'b1);
        wait_done(cyc);
        checks++;
        if (sum !== 16'h9623 || cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h cout=%b want 9623/0", sum, cout);
        end
        tick();
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add_basic();
        test_carry();
        test_err();
        test_ignore_start();
        test_abort();
        test_back_to_back();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
